// File: rtl/video_pkg.sv
// Shared constants and helpers for the video frame packer.
// PACKER_RGB565_EN selects 16-bit RGB565 slots instead of 32-bit zero-padded slots.
package video_pkg;

`ifdef PACKER_RGB565_EN
  localparam int PIX_SLOT_W = 16;
`else
  localparam int PIX_SLOT_W = 32;
`endif

  function automatic int pix_per_word(input int mem_w);
    return mem_w / PIX_SLOT_W;
  endfunction

  function automatic int bytes_per_word(input int mem_w);
    return mem_w / 8;
  endfunction

  // Keep the top 5/6/5 bits of R, G, B.
  function automatic logic [15:0] rgb888_to_565(input logic [23:0] p);
    return {p[23:19], p[15:10], p[7:3]};
  endfunction

endpackage

// File: rtl/pix_word_accum.sv
// Slot counter and word accumulator for the frame packer.
// o_word always shows the accumulated word with the current pixel inserted, so the
// top level can load it straight into the output register on a completing accept.
// PACKER_RGB565_EN changes the slot format (see video_pkg).
module pix_word_accum
  import video_pkg::*;
#(
  parameter int PIX_DATA_WIDTH = 24,
  parameter int MEM_DATA_WIDTH = 256
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_clear,
  input  logic                      i_accept,
  input  logic                      i_line_end,
  input  logic [PIX_DATA_WIDTH-1:0] i_pix,
  output logic                      o_complete,
  output logic [MEM_DATA_WIDTH-1:0] o_word
);

  localparam int PPW    = pix_per_word(MEM_DATA_WIDTH);
  localparam int SLOT_W = (PPW > 1) ? $clog2(PPW) : 1;

  logic [SLOT_W-1:0]         r_slot;
  logic [MEM_DATA_WIDTH-1:0] r_acc;
  logic [PIX_SLOT_W-1:0]     w_pix_slot;

  // Convert the incoming pixel to its slot format.
  always_comb begin
`ifdef PACKER_RGB565_EN
    w_pix_slot = rgb888_to_565(i_pix[23:0]);
`else
    w_pix_slot = PIX_SLOT_W'(i_pix);
`endif
  end

  // Insert the current pixel at the current slot; later slots stay zero.
  always_comb begin
    o_word = r_acc;
    for (int k = 0; k < PPW; k++) begin
      if (r_slot == SLOT_W'(k)) begin
        o_word[k*PIX_SLOT_W +: PIX_SLOT_W] = w_pix_slot;
      end
    end
  end

  assign o_complete = (r_slot == SLOT_W'(PPW - 1)) || i_line_end;

  // Slot counter and accumulator; cleared on frame sync and after each completed word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_slot <= '0;
      r_acc  <= '0;
    end else if (i_clear) begin
      r_slot <= '0;
      r_acc  <= '0;
    end else if (i_accept) begin
      if (o_complete) begin
        r_slot <= '0;
        r_acc  <= '0;
      end else begin
        r_slot <= r_slot + 1'b1;
        r_acc  <= o_word;
      end
    end
  end

endmodule

// File: rtl/video_frame_packer.sv
// Packs a valid/ready pixel stream into wide memory words with byte addresses,
// a line-end marker and a frame-done pulse.
// PACKER_RGB565_EN: pack each pixel as 16-bit RGB565 instead of 32-bit zero-padded.
module video_frame_packer
  import video_pkg::*;
#(
  parameter int PIX_DATA_WIDTH = 24,
  parameter int MEM_DATA_WIDTH = 256,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                      video_clk,
  input  logic                      rst,
  input  logic                      frame_sync_n,
  input  logic [PIX_DATA_WIDTH-1:0] video_data_in,
  input  logic                      video_data_valid,
  output logic                      video_ready,
  input  logic [15:0]               video_width_out,
  input  logic [15:0]               video_height_out,
  input  logic [ADDR_WIDTH-1:0]     frame_base_addr,
  input  logic [ADDR_WIDTH-1:0]     line_stride,
  output logic [MEM_DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic                      wr_last,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic                      frame_done
);

  localparam int BYTES_PER_WORD = bytes_per_word(MEM_DATA_WIDTH);

  logic [15:0]               r_width;
  logic [15:0]               r_height;
  logic [ADDR_WIDTH-1:0]     r_stride;
  logic [15:0]               r_x;
  logic [15:0]               r_y;
  logic [ADDR_WIDTH-1:0]     r_line_base;
  logic [ADDR_WIDTH-1:0]     r_word_addr;
  logic [MEM_DATA_WIDTH-1:0] r_wr_data;
  logic [ADDR_WIDTH-1:0]     r_wr_addr;
  logic                      r_wr_last;
  logic                      r_wr_eof;
  logic                      r_wr_valid;

  logic                      w_active;
  logic                      w_accept;
  logic                      w_line_end;
  logic                      w_complete;
  logic                      w_load;
  logic [MEM_DATA_WIDTH-1:0] w_word;

  // Pixels are only packed inside a non-empty frame that has lines left.
  assign w_active   = frame_sync_n && (r_width != 16'd0) && (r_height != 16'd0) &&
                      (r_y < r_height);
  assign w_line_end = (r_x == r_width - 16'd1);
  assign w_accept   = video_data_valid && video_ready && w_active;
  assign w_load     = w_accept && w_complete;

  // Stall only a completing pixel, and only while the output word cannot move.
  assign video_ready = !(w_active && w_complete && r_wr_valid && !wr_ready);
  assign frame_done  = r_wr_valid && wr_ready && r_wr_eof;

  assign wr_data  = r_wr_data;
  assign wr_addr  = r_wr_addr;
  assign wr_last  = r_wr_last;
  assign wr_valid = r_wr_valid;

  pix_word_accum #(
    .PIX_DATA_WIDTH (PIX_DATA_WIDTH),
    .MEM_DATA_WIDTH (MEM_DATA_WIDTH)
  ) u_accum (
    .i_clk      (video_clk),
    .i_rst      (rst),
    .i_clear    (!frame_sync_n),
    .i_accept   (w_accept),
    .i_line_end (w_line_end),
    .i_pix      (video_data_in),
    .o_complete (w_complete),
    .o_word     (w_word)
  );

  // Config shadow, pixel position and word address tracking.
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      r_width     <= '0;
      r_height    <= '0;
      r_stride    <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_line_base <= '0;
      r_word_addr <= '0;
    end else if (!frame_sync_n) begin
      r_width     <= video_width_out;
      r_height    <= video_height_out;
      r_stride    <= line_stride;
      r_x         <= '0;
      r_y         <= '0;
      r_line_base <= frame_base_addr;
      r_word_addr <= frame_base_addr;
    end else if (w_accept) begin
      if (w_line_end) begin
        r_x         <= '0;
        r_y         <= r_y + 16'd1;
        r_line_base <= r_line_base + r_stride;
        r_word_addr <= r_line_base + r_stride;
      end else begin
        r_x <= r_x + 16'd1;
        if (w_complete) begin
          r_word_addr <= r_word_addr + ADDR_WIDTH'(BYTES_PER_WORD);
        end
      end
    end
  end

  // Output word register; frame sync never drops a pending word.
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      r_wr_data  <= '0;
      r_wr_addr  <= '0;
      r_wr_last  <= 1'b0;
      r_wr_eof   <= 1'b0;
      r_wr_valid <= 1'b0;
    end else if (w_load) begin
      r_wr_data  <= w_word;
      r_wr_addr  <= r_word_addr;
      r_wr_last  <= w_line_end;
      r_wr_eof   <= w_line_end && (r_y == r_height - 16'd1);
      r_wr_valid <= 1'b1;
    end else if (wr_ready) begin
      r_wr_valid <= 1'b0;
    end
  end

endmodule
